// File: rtl/peripheral_control_pkg.sv
// Shared definitions for the peripheral port: bus widths, register offsets, TCON bits.
// Optional SYSTICK counter is controlled by the PERI_SYSTICK_EN macro.
package peripheral_control_pkg;

   localparam int MEM_BUS      = 32;
   localparam int MEM_ADDR_BUS = 32;

   // Register select is the word offset addr[4:2] inside the 32-byte window
   typedef enum logic [2:0] {
      PERI_TH      = 3'd0,
      PERI_TL      = 3'd1,
      PERI_TCON    = 3'd2,
      PERI_LED     = 3'd3,
      PERI_SWITCH  = 3'd4,
      PERI_DIGI    = 3'd5,
      PERI_SYSTICK = 3'd6,
      PERI_RSVD    = 3'd7
   } peri_reg_e;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   typedef struct packed {
      logic               rd;
      logic               wr;
      peri_reg_e          sel;
      logic [MEM_BUS-1:0] wdata;
   } peri_req_t;

endpackage

// File: rtl/peripheral_control_seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/peripheral_control.sv
// Memory-mapped timer / LED / switch / seven-segment / systick responder on the CPU peripheral port.
// Define PERI_SYSTICK_EN to build the free-running SYSTICK counter at offset 0x18.
module peripheral_control
   import peripheral_control_pkg::*;
#(
   parameter int          SCAN_DIV  = 50000,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    peri_cre_i,
   input  logic                    peri_cwe_i,
   input  logic [MEM_ADDR_BUS-1:0] ram_peri_addr_i,
   input  logic [MEM_BUS-1:0]      ram_peri_wdata_i,
   output logic [MEM_BUS-1:0]      peri_rdata_o,
   input  logic [7:0]              switch_i,
   output logic [7:0]              led_o,
   output logic [3:0]              an_o,
   output logic [7:0]              seg_o,
   output logic                    irq_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   peri_req_t   req;
   logic        hit;
   logic [31:0] th, tl;
   logic [2:0]  tcon;
   logic [7:0]  led, sw_s1, sw_s2;
   logic [15:0] digi;
   logic [PW-1:0] presc;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic [6:0]  seg7;
   logic        ovf, ovf_irq;
   logic        unused_addr;

   assign hit         = (ram_peri_addr_i[31:5] == BASE_ADDR[31:5]);
   assign unused_addr = ^ram_peri_addr_i[1:0];

   always_comb begin
      req.rd    = peri_cre_i & hit;
      req.wr    = peri_cwe_i & hit;
      req.sel   = peri_reg_e'(ram_peri_addr_i[4:2]);
      req.wdata = ram_peri_wdata_i;
   end

   assign ovf     = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
   assign ovf_irq = ovf & tcon[TCON_IE];

   // A CPU write to TL beats the count; a TCON write can never clear a same-cycle overflow set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (req.wr && req.sel == PERI_TH) th <= req.wdata;
         if (req.wr && req.sel == PERI_TL) tl <= req.wdata;
         else if (tcon[TCON_EN])           tl <= ovf ? th : tl + 32'd1;
         if (req.wr && req.sel == PERI_TCON)
            tcon <= {req.wdata[TCON_IS] | ovf_irq, req.wdata[TCON_IE], req.wdata[TCON_EN]};
         else if (ovf_irq)
            tcon[TCON_IS] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led   <= '0;
         digi  <= '0;
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         if (req.wr && req.sel == PERI_LED)  led  <= req.wdata[7:0];
         if (req.wr && req.sel == PERI_DIGI) digi <= req.wdata[15:0];
         sw_s1 <= switch_i;
         sw_s2 <= sw_s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

`ifdef PERI_SYSTICK_EN
   logic [31:0] systick;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) systick <= '0;
      else      systick <= systick + 32'd1;
   end
`endif

   always_comb begin
      peri_rdata_o = '0;
      if (req.rd) begin
         case (req.sel)
            PERI_TH:      peri_rdata_o = th;
            PERI_TL:      peri_rdata_o = tl;
            PERI_TCON:    peri_rdata_o = {29'd0, tcon};
            PERI_LED:     peri_rdata_o = {24'd0, led};
            PERI_SWITCH:  peri_rdata_o = {24'd0, sw_s2};
            PERI_DIGI:    peri_rdata_o = {16'd0, digi};
`ifdef PERI_SYSTICK_EN
            PERI_SYSTICK: peri_rdata_o = systick;
`endif
            default:      peri_rdata_o = '0;
         endcase
      end
   end

   assign nib = digi[{idx, 2'b00} +: 4];

   seg7_decoder u_seg7 (
      .hex (nib),
      .seg (seg7)
   );

   assign an_o  = ~(4'b0001 << idx);
   assign seg_o = {1'b1, seg7};
   assign led_o = led;
   assign irq_o = tcon[TCON_IS];

endmodule

// File: tb/tb_peripheral_control.sv
// Scoreboarded random/directed bench for peripheral_control against a cycle-level register model.
module tb_peripheral_control;

   localparam int          SD   = 4;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0, rst = 1'b0, cre = 1'b0, cwe = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic [7:0]  sw = '0, led, seg;
   logic [3:0]  an;
   logic        irq;

   peripheral_control #(.SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
      .clk              (clk),
      .rst              (rst),
      .peri_cre_i       (cre),
      .peri_cwe_i       (cwe),
      .ram_peri_addr_i  (addr),
      .ram_peri_wdata_i (wdata),
      .peri_rdata_o     (rdata),
      .switch_i         (sw),
      .led_o            (led),
      .an_o             (an),
      .seg_o            (seg),
      .irq_o            (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [31:0] rdata;
      logic [7:0]  led;
      logic        irq;
      logic [3:0]  an;
      logic [7:0]  seg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, passed = 0;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference state: register contents after the most recent clock edge
   logic [31:0] m_th, m_tl;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led, m_s1, m_s2;
   logic [15:0] m_digi;
   longint      m_cyc;

   task automatic model_reset();
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_s1 = 0; m_s2 = 0; m_digi = 0; m_cyc = 0;
   endtask

   // Apply one clock edge using the inputs that were held across it
   task automatic model_step();
      logic        ovf, set_is;
      logic [31:0] n_tl;
      logic [2:0]  n_tcon;
      if (!rst) begin
         model_reset();
         return;
      end
      ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      set_is = ovf && m_tcon[1];
      n_tl   = !m_tcon[0] ? m_tl : (ovf ? m_th : m_tl + 32'd1);
      n_tcon = m_tcon | {set_is, 2'b00};
      if (cwe && addr[31:5] == BASE[31:5]) begin
         case (int'(addr[4:2]))
            0: m_th   = wdata;
            1: n_tl   = wdata;
            2: n_tcon = {wdata[2] | set_is, wdata[1:0]};
            3: m_led  = wdata[7:0];
            5: m_digi = wdata[15:0];
            default: ;
         endcase
      end
      m_tl   = n_tl;
      m_tcon = n_tcon;
      m_s2   = m_s1;
      m_s1   = sw;
      m_cyc++;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'h0;
      case (int'(a[4:2]))
         0: return m_th;
         1: return m_tl;
         2: return {29'd0, m_tcon};
         3: return {24'd0, m_led};
         4: return {24'd0, m_s2};
         5: return {16'd0, m_digi};
`ifdef PERI_SYSTICK_EN
         6: return 32'(m_cyc);
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic r_n, input logic c_r, input logic c_w,
                        input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
      exp_t e;
      int   dig;
      @(posedge clk);
      #1;
      model_step();
      rst = r_n; cre = c_r; cwe = c_w; addr = a; wdata = d; sw = s;
      if (!r_n) model_reset();
      dig     = int'((m_cyc / SD) % 4);
      e.rd    = c_r;
      e.rdata = model_read(a);
      e.led   = m_led;
      e.irq   = m_tcon[2];
      e.an    = 4'hF & ~(4'h1 << dig);
      e.seg   = seg_tab[(m_digi >> (4 * dig)) & 16'hF];
      exp_q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s got %h expected %h", nm, got, want);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.rd) check($sformatf("rdata@%h", addr), rdata, e.rdata);
         else      check("rdata_idle", rdata, 32'h0);
         check("led", {24'd0, led}, {24'd0, e.led});
         check("irq", {31'd0, irq}, {31'd0, e.irq});
         check("an",  {28'd0, an},  {28'd0, e.an});
         check("seg", {24'd0, seg}, {24'd0, e.seg});
      end
   end

   initial begin
      logic [31:0] a, d;
      model_reset();
      repeat (2) @(posedge clk);
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 1, 0, BASE + 32'(4 * i), 0, 0);

      // reload with interrupt, then clear by writing TCON with bit2 low
      drive(1, 0, 1, BASE + 32'h00, 32'hFFFF_FFFD, 0);
      drive(1, 0, 1, BASE + 32'h04, 32'hFFFF_FFFE, 0);
      drive(1, 0, 1, BASE + 32'h08, 32'h3, 0);
      drive(1, 1, 0, BASE + 32'h04, 0, 0);
      drive(1, 1, 0, BASE + 32'h04, 0, 0);
      drive(1, 1, 0, BASE + 32'h08, 0, 0);
      drive(1, 1, 1, BASE + 32'h08, 32'h3, 0);
      drive(1, 1, 0, BASE + 32'h08, 0, 0);

      // reload without interrupt; TL write lands on the overflow cycle
      drive(1, 0, 1, BASE + 32'h08, 32'h1, 0);
      drive(1, 0, 1, BASE + 32'h04, 32'hFFFF_FFFE, 0);
      drive(1, 1, 0, BASE + 32'h04, 0, 0);
      drive(1, 1, 1, BASE + 32'h04, 32'h5, 0);
      drive(1, 1, 0, BASE + 32'h04, 0, 0);
      drive(1, 1, 0, BASE + 32'h08, 0, 0);
      drive(1, 0, 1, BASE + 32'h08, 32'h0, 0);

      drive(1, 0, 1, BASE + 32'h14, 32'h1234, 0);
      repeat (20) drive(1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 4; i++) drive(1, 1, 0, BASE + 32'h10, 0, 8'hA5);
      drive(1, 1, 1, BASE + 32'h0C, 32'h3C, 8'hA5);
      drive(1, 1, 0, BASE + 32'h0C, 0, 8'hA5);
      drive(1, 0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 8'hA5);
      drive(1, 1, 0, BASE + 32'h20, 0, 8'hA5);
      for (int i = 0; i < 7; i++) drive(1, 1, 0, BASE + 32'(4 * i), 0, 8'hA5);
      drive(1, 1, 0, BASE + 32'h18, 0, 8'hA5);
      repeat (5) drive(1, 0, 0, 0, 0, 8'hA5);
      drive(1, 1, 0, BASE + 32'h18, 0, 8'hA5);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 0) ? BASE + 32'h20 : $urandom;
         else
            a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: d = $urandom;
            1: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2: d = 32'($urandom_range(0, 7));
            default: d = $urandom;
         endcase
         drive(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), a, d, 8'($urandom));
      end

      drive(1, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
